// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate generator feeding the ALU operand mux.
// Decodes each instruction's opcode, extends its immediate (sign / zero / upper /
// branch), and holds results in a 2-entry skid buffer with valid/ready on both
// sides. Also keeps a saturating count of delivered immediates.
// Optional macro IMM_EXT_BRANCH_SHIFT_EN: branch immediates are shifted left by 2.
//
// state | meaning
// ------+-----------------------------
// EMPTY | no buffered entries
// ONE   | one entry, at the head
// TWO   | buffer full, in_ready low
module imm_extend_stage #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [1:0]        out_mode,
    output logic [CNT_W-1:0]  imm_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_LUI    = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    state_t state, state_next;

    logic [OPC_W-1:0]  opcode;
    logic [IMM_W-1:0]  imm_field;
    logic [DATA_W-1:0] ext_imm;
    logic [1:0]        ext_mode;
    logic [DATA_W-1:0] sext, zext;

    logic [DATA_W-1:0] imm_q  [2];
    logic [1:0]        mode_q [2];
    logic              rd_ptr, wr_ptr;
    logic              accept, deliver;
    logic              unused_instr_bits;

    assign opcode            = in_instr[31 -: OPC_W];
    assign imm_field         = in_instr[IMM_W-1:0];
    assign unused_instr_bits = ^in_instr[31-OPC_W:IMM_W];
    assign sext              = DATA_W'($signed(imm_field));
    assign zext              = DATA_W'(imm_field);

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign out_imm   = imm_q[rd_ptr];
    assign out_mode  = mode_q[rd_ptr];

    // Opcode decode and immediate extension for the incoming instruction.
    always_comb begin
        ext_imm  = sext;
        ext_mode = MODE_SIGN;
        if (opcode == OPC_W'(6'h0F)) begin
            ext_imm  = zext << IMM_W;
            ext_mode = MODE_LUI;
        end else if (opcode == OPC_W'(6'h0C) || opcode == OPC_W'(6'h0D) ||
                     opcode == OPC_W'(6'h0E)) begin
            ext_imm  = zext;
            ext_mode = MODE_ZERO;
        end else if (opcode >= OPC_W'(6'h04) && opcode <= OPC_W'(6'h07)) begin
`ifdef IMM_EXT_BRANCH_SHIFT_EN
            ext_imm  = sext << 2;
`else
            ext_imm  = sext;
`endif
            ext_mode = MODE_BRANCH;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    // Next occupancy from accept/deliver; flush empties the buffer.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_next = ONE;
                ONE: begin
                    if (accept && !deliver)      state_next = TWO;
                    else if (!accept && deliver) state_next = EMPTY;
                end
                TWO:     if (deliver) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next occupancy so it is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) in_ready <= 1'b1;
        else       in_ready <= (state_next != TWO);
    end

    // Buffer storage and FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i]  <= '0;
                mode_q[i] <= MODE_SIGN;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (accept) begin
                imm_q[wr_ptr]  <= ext_imm;
                mode_q[wr_ptr] <= ext_mode;
                wr_ptr         <= ~wr_ptr;
            end
            if (deliver) rd_ptr <= ~rd_ptr;
        end
    end

    // Saturating count of delivered immediates; flush does not clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            imm_count <= '0;
        else if (!flush && deliver && imm_count != {CNT_W{1'b1}})
            imm_count <= imm_count + 1'b1;
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: queue-based reference model checked every cycle,
// plus directed literal cases. CNT_W is reduced to 4 so saturation is reached.
module tb_imm_extend_stage;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [31:0]      in_instr, out_imm;
    logic [1:0]       out_mode;
    logic [CNT_W-1:0] imm_count;

    int total = 0;
    int bad   = 0;

    logic [33:0] mq[$];
    int          mcnt;

    imm_extend_stage #(.IMM_W(16), .DATA_W(32), .OPC_W(6), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_mode(out_mode), .imm_count(imm_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {mode, imm} from the opcode rules, using plain integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] ins);
        int op;
        int s;
        int u;
        logic [31:0] v;
        logic [1:0]  m;
        op = int'(ins[31:26]);
        s  = int'($signed(ins[15:0]));
        u  = int'(ins[15:0]);
        if (op == 15) begin
            v = 32'(u * 65536); m = 2'd2;
        end else if (op >= 12 && op <= 14) begin
            v = 32'(u); m = 2'd1;
        end else if (op >= 4 && op <= 7) begin
`ifdef IMM_EXT_BRANCH_SHIFT_EN
            v = 32'(s * 4);
`else
            v = 32'(s);
`endif
            m = 2'd3;
        end else begin
            v = 32'(s); m = 2'd0;
        end
        return {m, v};
    endfunction

    // Reference model update at each active edge.
    always @(posedge clk or posedge reset) begin
        bit acc, del;
        if (reset) begin
            mq.delete();
            mcnt = 0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            del = out_ready && (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (del) begin
                    void'(mq.pop_front());
                    if (mcnt < CMAX) mcnt = mcnt + 1;
                end
                if (acc) mq.push_back(model(in_instr));
            end
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
            check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("imm_count", 32'(imm_count), 32'(mcnt));
            if (mq.size() > 0) begin
                check("out_imm", out_imm, mq[0][31:0]);
                check("out_mode", 32'(out_mode), 32'(mq[0][33:32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] dir_instr [4];
    logic [31:0] dir_imm   [4];
    logic [1:0]  dir_mode  [4];
    logic [5:0]  ops [10];

    initial begin
        dir_instr[0] = 32'h2008FFFC; dir_imm[0] = 32'hFFFFFFFC; dir_mode[0] = 2'b00;
        dir_instr[1] = 32'h35088000; dir_imm[1] = 32'h00008000; dir_mode[1] = 2'b01;
        dir_instr[2] = 32'h3C081234; dir_imm[2] = 32'h12340000; dir_mode[2] = 2'b10;
        dir_instr[3] = 32'h1000FFFF;
`ifdef IMM_EXT_BRANCH_SHIFT_EN
        dir_imm[3] = 32'hFFFFFFFC;
`else
        dir_imm[3] = 32'hFFFFFFFF;
`endif
        dir_mode[3] = 2'b11;
        ops = '{6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_mode", 32'(out_mode), 32'd0);
        check("rst_imm_count", 32'(imm_count), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Single instructions, consumer always ready: 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = dir_instr[i];
            tick();
            in_valid = 1'b0;
            check("dir_valid", 32'(out_valid), 32'd1);
            check("dir_imm", out_imm, dir_imm[i]);
            check("dir_mode", 32'(out_mode), 32'(dir_mode[i]));
            tick();
            check("dir_drained", 32'(out_valid), 32'd0);
        end
        check("dir_count", 32'(imm_count), 32'd4);

        // Backpressure with three back-to-back instructions.
        reset_pulse();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h20080001;
        tick();
        in_instr = 32'h20080002;
        tick();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_head1", out_imm, 32'd1);
        in_instr = 32'h20080003;
        tick();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_head", out_imm, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_head2", out_imm, 32'd2);
        tick();
        in_valid = 1'b0;
        check("bp_head3", out_imm, 32'd3);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_count", 32'(imm_count), 32'd3);

        // Flush while full, with a same-cycle valid input.
        reset_pulse();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h3508000A;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0; in_valid = 1'b1;
        tick(); tick();
        check("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        check("fl_count", 32'(imm_count), 32'd1);
        tick();
        check("fl_no_accept", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a transfer.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h3C08ABCD;
        tick(); tick();
        #1 reset = 1'b1;
        #1;
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_imm", out_imm, 32'd0);
        check("ar_out_mode", 32'(out_mode), 32'd0);
        check("ar_imm_count", 32'(imm_count), 32'd0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("ar_release_ready", 32'(in_ready), 32'd1);

        // Randomized traffic checked by the model; long enough to saturate the count.
        for (int c = 0; c < 4000; c++) begin
            tick();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 31) == 0);
            in_instr  = $urandom;
            if ($urandom_range(0, 1) == 1)
                in_instr[31:26] = ops[$urandom_range(0, 9)];
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        tick();
        check("sat_count", 32'(imm_count), 32'(CMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
